dut_pin_sequencer: RTL and testbench



---
 rtl/dut_pin_sequencer.sv | 159 +++++++++++++++
 tb/tb_dut_pin_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dut_pin_sequencer.sv
// Pin sequencer: sits between the test runner and the chip-under-test pins.
// Accepts one stimulus vector per handshake, drives it onto the selected target's pins,
// waits a per-vector settle time, samples the chip response through a 2-flop synchroniser
// and returns it over a valid/ready handshake. Out-of-range targets are answered at once
// with an error response and leave the pins untouched.
//
// Ports:
//   clock, reset_n                 system clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake
//   req_target/req_mosi/req_wait   target index, stimulus word, extra settle cycles
//   resp_valid/resp_ready          response handshake
//   resp_miso/resp_target/resp_err captured word, echoed target, bad-target flag
//   pin_sel/pin_mosi/pin_active    physical pin drive
//   pin_miso                       asynchronous chip response
//   txn_count                      completed good transactions (saturating)
module dut_pin_sequencer #(
  parameter int unsigned IO_WIDTH    = 24,
  parameter int unsigned SEL_WIDTH   = 5,
  parameter int unsigned WAIT_WIDTH  = 4,
  parameter int unsigned NUM_TARGETS = 20
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [SEL_WIDTH-1:0]  req_target,
  input  logic [IO_WIDTH-1:0]   req_mosi,
  input  logic [WAIT_WIDTH-1:0] req_wait,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IO_WIDTH-1:0]   resp_miso,
  output logic [SEL_WIDTH-1:0]  resp_target,
  output logic                  resp_err,
  output logic [SEL_WIDTH-1:0]  pin_sel,
  output logic [IO_WIDTH-1:0]   pin_mosi,
  output logic                  pin_active,
  input  logic [IO_WIDTH-1:0]   pin_miso,
  output logic [15:0]           txn_count
);

  localparam int unsigned CntW = WAIT_WIDTH + 1;
  // One extra bit so NUM_TARGETS == 2**SEL_WIDTH is still representable.
  localparam logic [SEL_WIDTH:0] NumTargets = NUM_TARGETS[SEL_WIDTH:0];

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  state_e               r_state, w_state_next;
  logic [CntW-1:0]      r_cnt, w_cnt_next;
  logic [IO_WIDTH-1:0]  r_sync1, r_sync2;
  logic [IO_WIDTH-1:0]  r_resp_miso, w_resp_miso_next;
  logic [SEL_WIDTH-1:0] r_resp_target, w_resp_target_next;
  logic                 r_resp_err, w_resp_err_next;
  logic [SEL_WIDTH-1:0] r_pin_sel, w_pin_sel_next;
  logic [IO_WIDTH-1:0]  r_pin_mosi, w_pin_mosi_next;
  logic                 r_pin_active, w_pin_active_next;
  logic [15:0]          r_txn_count, w_txn_count_next;
  logic                 w_target_ok;

  assign w_target_ok = ({1'b0, req_target} < NumTargets);

  // Synchroniser runs every cycle regardless of state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_miso;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_resp_miso   <= '0;
      r_resp_target <= '0;
      r_resp_err    <= 1'b0;
      r_pin_sel     <= '0;
      r_pin_mosi    <= '0;
      r_pin_active  <= 1'b0;
      r_txn_count   <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_resp_miso   <= w_resp_miso_next;
      r_resp_target <= w_resp_target_next;
      r_resp_err    <= w_resp_err_next;
      r_pin_sel     <= w_pin_sel_next;
      r_pin_mosi    <= w_pin_mosi_next;
      r_pin_active  <= w_pin_active_next;
      r_txn_count   <= w_txn_count_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_cnt_next         = r_cnt;
    w_resp_miso_next   = r_resp_miso;
    w_resp_target_next = r_resp_target;
    w_resp_err_next    = r_resp_err;
    w_pin_sel_next     = r_pin_sel;
    w_pin_mosi_next    = r_pin_mosi;
    w_pin_active_next  = r_pin_active;
    w_txn_count_next   = r_txn_count;
    req_ready          = 1'b0;
    resp_valid         = 1'b0;

    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_resp_target_next = req_target;
          if (w_target_ok) begin
            w_pin_sel_next    = req_target;
            w_pin_mosi_next   = req_mosi;
            w_pin_active_next = 1'b1;
            // +2 covers the synchroniser depth so stage 2 reflects the new vector.
            w_cnt_next        = {1'b0, req_wait} + CntW'(2);
            w_state_next      = StSettle;
          end else begin
            w_resp_err_next  = 1'b1;
            w_resp_miso_next = '0;
            w_state_next     = StResp;
          end
        end
      end
      StSettle: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CntW'(1);
        end else begin
          w_resp_miso_next  = r_sync2;
          w_resp_err_next   = 1'b0;
          w_pin_active_next = 1'b0;
          w_state_next      = StResp;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = StIdle;
          if (!r_resp_err && (r_txn_count != 16'hFFFF)) begin
            w_txn_count_next = r_txn_count + 16'd1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign resp_miso   = r_resp_miso;
  assign resp_target = r_resp_target;
  assign resp_err    = r_resp_err;
  assign pin_sel     = r_pin_sel;
  assign pin_mosi    = r_pin_mosi;
  assign pin_active  = r_pin_active;
  assign txn_count   = r_txn_count;

endmodule

// File: tb/tb_dut_pin_sequencer.sv
// Bench for dut_pin_sequencer. The chip is modelled as pin_miso = pin_mosi << 1.
// Expected results come from a transaction-level model: a good vector is answered
// req_wait+3 edges after the accept edge with chip(mosi); a rejected one is answered in
// the cycle right after the accept edge with err=1, miso=0 and untouched pins.
module tb_dut_pin_sequencer;
  localparam int unsigned IoW   = 24;
  localparam int unsigned SelW  = 5;
  localparam int unsigned WaitW = 4;
  localparam int unsigned NumT  = 20;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [SelW-1:0]  req_target = '0;
  logic [IoW-1:0]   req_mosi = '0;
  logic [WaitW-1:0] req_wait = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [IoW-1:0]   resp_miso;
  logic [SelW-1:0]  resp_target;
  logic             resp_err;
  logic [SelW-1:0]  pin_sel;
  logic [IoW-1:0]   pin_mosi;
  logic             pin_active;
  logic [IoW-1:0]   pin_miso;
  logic [15:0]      txn_count;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [15:0]     m_count = '0;
  logic [SelW-1:0] m_sel = '0;
  logic [IoW-1:0]  m_mosi = '0;

  dut_pin_sequencer #(
    .IO_WIDTH   (IoW),
    .SEL_WIDTH  (SelW),
    .WAIT_WIDTH (WaitW),
    .NUM_TARGETS(NumT)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_mosi   (req_mosi),
    .req_wait   (req_wait),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_miso  (resp_miso),
    .resp_target(resp_target),
    .resp_err   (resp_err),
    .pin_sel    (pin_sel),
    .pin_mosi   (pin_mosi),
    .pin_active (pin_active),
    .pin_miso   (pin_miso),
    .txn_count  (txn_count)
  );

  always #5 clock = ~clock;

  assign pin_miso = pin_mosi << 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request/response transaction. Called at #1 after a rising edge with the DUT idle.
  // hold: cycles resp_ready is held low; pend: keep req_valid high into the next call.
  task automatic run_txn(input logic [SelW-1:0] tgt, input logic [IoW-1:0] mosi,
                         input logic [WaitW-1:0] wt, input int hold, input bit pend);
    bit             bad;
    int             lat;
    int             act;
    int             exp_lat;
    logic [IoW-1:0] exp_miso;
    logic [IoW-1:0] chip;

    bad      = (32'(tgt) >= NumT);
    chip     = mosi << 1;
    exp_lat  = bad ? 0 : int'(wt) + 3;
    exp_miso = bad ? '0 : chip;

    req_target = tgt;
    req_mosi   = mosi;
    req_wait   = wt;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    if (!bad) begin
      m_sel  = tgt;
      m_mosi = mosi;
    end

    lat = 0;
    act = 0;
    while (!resp_valid && lat < 40) begin
      if (pin_active) act++;
      @(posedge clock); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("pin_active_cycles", 32'(act), bad ? 32'd0 : 32'(exp_lat));
    check("pin_active_off", 32'(pin_active), 32'd0);
    check("pin_sel", 32'(pin_sel), 32'(m_sel));
    check("pin_mosi", 32'(pin_mosi), 32'(m_mosi));
    check("resp_miso", 32'(resp_miso), 32'(exp_miso));
    check("resp_target", 32'(resp_target), 32'(tgt));
    check("resp_err", 32'(resp_err), 32'(bad));

    for (int i = 0; i < hold; i++) begin
      if (pend) req_valid = 1'b1;
      @(posedge clock); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
      check("hold_miso", 32'(resp_miso), 32'(exp_miso));
      check("hold_target", 32'(resp_target), 32'(tgt));
      check("hold_err", 32'(resp_err), 32'(bad));
    end

    if (pend) req_valid = 1'b1;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    if (!bad && m_count != 16'hFFFF) m_count++;
    check("post_hs_valid", 32'(resp_valid), 32'd0);
    check("post_hs_ready", 32'(req_ready), 32'd1);
    check("txn_count", 32'(txn_count), 32'(m_count));
  endtask

  initial begin
    bit seen;

    repeat (2) @(posedge clock);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_pin_active", 32'(pin_active), 32'd0);
    check("rst_txn_count", 32'(txn_count), 32'd0);
    check("rst_resp_miso", 32'(resp_miso), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Directed vectors
    run_txn(5'd3, 24'h000001, 4'd0, 0, 1'b0);
    run_txn(5'd3, 24'h800001, 4'd15, 0, 1'b0);
    run_txn(5'd31, 24'hABCDEF, 4'd7, 0, 1'b0);
    run_txn(5'd7, 24'h123456, 4'd2, 5, 1'b1);
    run_txn(5'd8, 24'h0F0F0F, 4'd1, 0, 1'b0);
    run_txn(5'd19, 24'hFFFFFF, 4'd3, 1, 1'b0);
    run_txn(5'd20, 24'h00FF00, 4'd0, 2, 1'b0);

    // Randomized vectors
    for (int n = 0; n < 40; n++) begin
      run_txn(SelW'($urandom_range(0, 31)), IoW'($urandom), WaitW'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)), n != 39 && ($urandom_range(0, 1) == 1));
    end
    req_valid = 1'b0;

    // Reset in the middle of a settle period
    req_target = 5'd5;
    req_mosi   = 24'h5A5A5A;
    req_wait   = 4'd10;
    req_valid  = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    m_count = '0;
    m_sel   = '0;
    m_mosi  = '0;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_resp_err", 32'(resp_err), 32'd0);
    check("mid_rst_resp_miso", 32'(resp_miso), 32'd0);
    check("mid_rst_resp_target", 32'(resp_target), 32'd0);
    check("mid_rst_pin_sel", 32'(pin_sel), 32'd0);
    check("mid_rst_pin_mosi", 32'(pin_mosi), 32'd0);
    check("mid_rst_pin_active", 32'(pin_active), 32'd0);
    check("mid_rst_txn_count", 32'(txn_count), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clock); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("no_resp_after_rst", 32'(seen), 32'd0);
    check("count_after_rst", 32'(txn_count), 32'd0);

    // Saturation of the transaction counter
    force dut.r_txn_count = 16'hFFFE;
    #1;
    release dut.r_txn_count;
    m_count = 16'hFFFE;
    @(posedge clock); #1;
    check("count_preset", 32'(txn_count), 32'h0000FFFE);
    run_txn(5'd1, 24'h000010, 4'd0, 0, 1'b0);
    run_txn(5'd2, 24'h000020, 4'd1, 0, 1'b0);
    run_txn(5'd4, 24'h000040, 4'd2, 0, 1'b0);
    check("count_saturated", 32'(txn_count), 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
